// File: rtl/sr_reg_bank.sv
// Bank of N clocked set/reset channels with selectable S=R=1 policy, edge pulses and conflict diagnostics.
// Latency: 1 clock from s/r/en to q; rise/fall/conflict/conflict_cnt are registered in the same edge.
// Backpressure: none; en=0 freezes all channel state and suppresses conflict recording.
module sr_reg_bank #(
   parameter int              N       = 8,
   parameter int              MODE    = 0,
   parameter logic [N-1:0]    RST_VAL = {N{1'b0}},
   parameter int              CNT_W   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [N-1:0]     s,
   input  logic [N-1:0]     r,
   input  logic             clr_err,
   output logic [N-1:0]     q,
   output logic [N-1:0]     rise,
   output logic [N-1:0]     fall,
   output logic [N-1:0]     conflict,
   output logic [CNT_W-1:0] conflict_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [N-1:0] q_nxt;
   logic [N-1:0] conf_vec;
   logic         conf_any;

   // Next channel state: per-bit SR decode, S=R=1 resolved by MODE (unknown MODE values hold).
   always_comb begin
      q_nxt = q;
      if (en) begin
         for (int i = 0; i < N; i++) begin
            case ({s[i], r[i]})
               2'b01:   q_nxt[i] = 1'b0;
               2'b10:   q_nxt[i] = 1'b1;
               2'b11: begin
                  case (MODE)
                     1:       q_nxt[i] = 1'b1;
                     2:       q_nxt[i] = 1'b0;
                     3:       q_nxt[i] = ~q[i];
                     default: q_nxt[i] = q[i];
                  endcase
               end
               default: q_nxt[i] = q[i];
            endcase
         end
      end
   end

   // Conflicts this cycle are only meaningful while the bank is enabled.
   always_comb begin
      conf_vec = {N{en}} & s & r;
      conf_any = |conf_vec;
   end

   // Channel state and change pulses; reset never produces a pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         q    <= RST_VAL;
         rise <= '0;
         fall <= '0;
      end else begin
         q    <= q_nxt;
         rise <= q_nxt & ~q;
         fall <= ~q_nxt & q;
      end
   end

   // Sticky conflict flags and saturating event counter; a fresh conflict beats clr_err.
   always_ff @(posedge clk) begin
      if (rst) begin
         conflict     <= '0;
         conflict_cnt <= '0;
      end else if (clr_err) begin
         conflict     <= conf_vec;
         conflict_cnt <= conf_any ? CNT_ONE : '0;
      end else begin
         conflict <= conflict | conf_vec;
         if (conf_any && (conflict_cnt != CNT_MAX)) begin
            conflict_cnt <= conflict_cnt + CNT_ONE;
         end
      end
   end

endmodule

// File: tb/tb_sr_reg_bank.sv
// Exercises five sr_reg_bank instances (MODE 0..3 with CNT_W=8, plus MODE 0 with CNT_W=2) on shared stimulus.
// A behavioural per-instance model predicts every output one edge ahead.
// Outputs are sampled 1 time unit after each rising edge.
module tb_sr_reg_bank;

   localparam int         NI  = 5;
   localparam logic [7:0] RV  = 8'hA5;

   logic       clk = 1'b0;
   logic       rst, en, clr_err;
   logic [7:0] s, r;

   logic [7:0] q_o[NI], rise_o[NI], fall_o[NI], conf_o[NI], cnt_o[NI];
   logic [1:0] cnt2;

   // reference model state
   logic [7:0] mq[NI], mrise[NI], mfall[NI], mconf[NI];
   int         mcnt[NI];
   int         mmode[NI];
   int         mmax[NI];

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 4; g++) begin : g_mode
      sr_reg_bank #(.N(8), .MODE(g), .RST_VAL(RV), .CNT_W(8)) u_dut (
         .clk(clk), .rst(rst), .en(en), .s(s), .r(r), .clr_err(clr_err),
         .q(q_o[g]), .rise(rise_o[g]), .fall(fall_o[g]),
         .conflict(conf_o[g]), .conflict_cnt(cnt_o[g])
      );
   end

   sr_reg_bank #(.N(8), .MODE(0), .RST_VAL(RV), .CNT_W(2)) u_dut_small (
      .clk(clk), .rst(rst), .en(en), .s(s), .r(r), .clr_err(clr_err),
      .q(q_o[4]), .rise(rise_o[4]), .fall(fall_o[4]),
      .conflict(conf_o[4]), .conflict_cnt(cnt2)
   );
   assign cnt_o[4] = {6'b0, cnt2};

   // Apply one cycle of stimulus, advance the model at the edge, then settle past the edge.
   task automatic step(input logic i_rst, input logic i_en, input logic [7:0] i_s,
                       input logic [7:0] i_r, input logic i_clr);
      logic [7:0] nq, c;
      rst = i_rst; en = i_en; s = i_s; r = i_r; clr_err = i_clr;
      @(posedge clk);
      for (int k = 0; k < NI; k++) begin
         if (i_rst) begin
            mq[k] = RV; mrise[k] = 0; mfall[k] = 0; mconf[k] = 0; mcnt[k] = 0;
         end else begin
            nq = mq[k];
            if (i_en) begin
               for (int b = 0; b < 8; b++) begin
                  if (i_s[b] && !i_r[b]) nq[b] = 1'b1;
                  else if (!i_s[b] && i_r[b]) nq[b] = 1'b0;
                  else if (i_s[b] && i_r[b]) begin
                     if (mmode[k] == 1) nq[b] = 1'b1;
                     else if (mmode[k] == 2) nq[b] = 1'b0;
                     else if (mmode[k] == 3) nq[b] = !mq[k][b];
                  end
               end
            end
            mrise[k] = nq & ~mq[k];
            mfall[k] = mq[k] & ~nq;
            mq[k]    = nq;
            c = i_en ? (i_s & i_r) : 8'h00;
            if (i_clr) begin
               mconf[k] = c;
               mcnt[k]  = (c != 0) ? 1 : 0;
            end else begin
               mconf[k] = mconf[k] | c;
               if (c != 0 && mcnt[k] < mmax[k]) mcnt[k] = mcnt[k] + 1;
            end
         end
      end
      #1;
   endtask

   task automatic test_reset();
      step(1'b1, 1'b1, 8'hFF, 8'h00, 1'b1);
      for (int k = 0; k < NI; k++) begin
         checks++;
         if (q_o[k] !== RV || rise_o[k] !== 8'h00 || fall_o[k] !== 8'h00 ||
             conf_o[k] !== 8'h00 || cnt_o[k] !== 8'h00) begin
            errors++;
            $display("FAIL reset inst%0d q=%h rise=%h fall=%h conf=%h cnt=%0d want q=%h others 0",
                     k, q_o[k], rise_o[k], fall_o[k], conf_o[k], cnt_o[k], RV);
         end
      end
   endtask

   task automatic test_set_reset();
      step(1'b0, 1'b1, 8'h0F, 8'hF0, 1'b0);
      for (int k = 0; k < NI; k++) begin
         checks++;
         if (q_o[k] !== 8'h0F || rise_o[k] !== 8'h0A || fall_o[k] !== 8'hA0) begin
            errors++;
            $display("FAIL set_reset inst%0d q=%h rise=%h fall=%h want q=0f rise=0a fall=a0",
                     k, q_o[k], rise_o[k], fall_o[k]);
         end
      end
      step(1'b0, 1'b1, 8'h00, 8'h00, 1'b0);
      for (int k = 0; k < NI; k++) begin
         checks++;
         if (q_o[k] !== 8'h0F || rise_o[k] !== 8'h00 || fall_o[k] !== 8'h00) begin
            errors++;
            $display("FAIL idle_hold inst%0d q=%h rise=%h fall=%h want q=0f no pulses",
                     k, q_o[k], rise_o[k], fall_o[k]);
         end
      end
   endtask

   task automatic test_enable_hold();
      for (int c = 0; c < 3; c++) begin
         step(1'b0, 1'b0, 8'hFF, (c == 2) ? 8'hFF : 8'h00, 1'b0);
         for (int k = 0; k < NI; k++) begin
            checks++;
            if (q_o[k] !== 8'h0F || rise_o[k] !== 8'h00 || conf_o[k] !== 8'h00 ||
                cnt_o[k] !== 8'h00) begin
               errors++;
               $display("FAIL en_hold inst%0d cyc%0d q=%h rise=%h conf=%h cnt=%0d want q=0f rest 0",
                        k, c, q_o[k], rise_o[k], conf_o[k], cnt_o[k]);
            end
         end
      end
      step(1'b0, 1'b1, 8'hFF, 8'h00, 1'b0);
      for (int k = 0; k < NI; k++) begin
         checks++;
         if (q_o[k] !== 8'hFF || rise_o[k] !== 8'hF0 || fall_o[k] !== 8'h00) begin
            errors++;
            $display("FAIL en_raise inst%0d q=%h rise=%h fall=%h want q=ff rise=f0 fall=00",
                     k, q_o[k], rise_o[k], fall_o[k]);
         end
      end
   endtask

   task automatic test_conflict_modes();
      // start each instance from a known clean state with q[0]=0
      step(1'b0, 1'b1, 8'h00, 8'h01, 1'b1);
      for (int c = 1; c <= 4; c++) begin
         step(1'b0, 1'b1, 8'h01, 8'h01, 1'b0);
         for (int k = 0; k < NI; k++) begin
            checks++;
            if (q_o[k] !== mq[k] || rise_o[k] !== mrise[k] || fall_o[k] !== mfall[k] ||
                conf_o[k] !== 8'h01 || cnt_o[k] !== 8'(mcnt[k])) begin
               errors++;
               $display("FAIL conflict_mode inst%0d cyc%0d q=%h/%h rise=%h/%h fall=%h/%h conf=%h/01 cnt=%0d/%0d",
                        k, c, q_o[k], mq[k], rise_o[k], mrise[k], fall_o[k], mfall[k],
                        conf_o[k], cnt_o[k], mcnt[k]);
            end
         end
      end
      // explicit per-mode expectations after four S=R=1 cycles from q[0]=0
      checks++;
      if (q_o[0][0] !== 1'b0 || q_o[1][0] !== 1'b1 || q_o[2][0] !== 1'b0 ||
          q_o[3][0] !== 1'b0 || cnt_o[0] !== 8'd4 || cnt_o[4] !== 8'd3) begin
         errors++;
         $display("FAIL mode_final q0=%b%b%b%b want 0100 cnt=%0d want 4 cnt_small=%0d want 3",
                  q_o[0][0], q_o[1][0], q_o[2][0], q_o[3][0], cnt_o[0], cnt_o[4]);
      end
   endtask

   task automatic test_saturation();
      int exp_small[5] = '{1, 2, 3, 3, 3};
      step(1'b0, 1'b1, 8'h00, 8'h00, 1'b1);
      for (int c = 0; c < 5; c++) begin
         step(1'b0, 1'b1, 8'h24, 8'h24, 1'b0);
         checks++;
         if (cnt_o[4] !== 8'(exp_small[c]) || cnt_o[0] !== 8'(c + 1)) begin
            errors++;
            $display("FAIL saturate cyc%0d cnt_small=%0d want %0d cnt=%0d want %0d",
                     c, cnt_o[4], exp_small[c], cnt_o[0], c + 1);
         end
      end
      step(1'b0, 1'b1, 8'h00, 8'h00, 1'b1);
      for (int k = 0; k < NI; k++) begin
         checks++;
         if (conf_o[k] !== 8'h00 || cnt_o[k] !== 8'h00) begin
            errors++;
            $display("FAIL clr_alone inst%0d conf=%h cnt=%0d want 0", k, conf_o[k], cnt_o[k]);
         end
      end
   endtask

   task automatic test_clr_with_conflict();
      step(1'b0, 1'b1, 8'h03, 8'h03, 1'b0);
      step(1'b0, 1'b1, 8'h80, 8'h80, 1'b1);
      for (int k = 0; k < NI; k++) begin
         checks++;
         if (conf_o[k] !== 8'h80 || cnt_o[k] !== 8'd1) begin
            errors++;
            $display("FAIL clr_vs_new inst%0d conf=%h cnt=%0d want conf=80 cnt=1",
                     k, conf_o[k], cnt_o[k]);
         end
      end
   endtask

   task automatic test_reset_mid_toggle();
      for (int c = 0; c < 3; c++) step(1'b0, 1'b1, 8'h01, 8'h01, 1'b0);
      step(1'b1, 1'b1, 8'h01, 8'h01, 1'b0);
      for (int k = 0; k < NI; k++) begin
         checks++;
         if (q_o[k] !== RV || rise_o[k] !== 8'h00 || fall_o[k] !== 8'h00 ||
             cnt_o[k] !== 8'h00 || conf_o[k] !== 8'h00) begin
            errors++;
            $display("FAIL rst_mid inst%0d q=%h rise=%h fall=%h cnt=%0d conf=%h want q=%h rest 0",
                     k, q_o[k], rise_o[k], fall_o[k], cnt_o[k], conf_o[k], RV);
         end
      end
      step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
      for (int k = 0; k < NI; k++) begin
         checks++;
         if (q_o[k] !== RV || rise_o[k] !== 8'h00 || fall_o[k] !== 8'h00) begin
            errors++;
            $display("FAIL post_rst inst%0d q=%h rise=%h fall=%h want q=%h no pulses",
                     k, q_o[k], rise_o[k], fall_o[k], RV);
         end
      end
   endtask

   task automatic test_random();
      logic [7:0] rs, rr;
      for (int c = 0; c < 300; c++) begin
         rs = 8'($urandom);
         rr = 8'($urandom);
         step(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0), rs, rr,
              ($urandom_range(0, 9) == 0));
         for (int k = 0; k < NI; k++) begin
            checks++;
            if (q_o[k] !== mq[k] || rise_o[k] !== mrise[k] || fall_o[k] !== mfall[k] ||
                conf_o[k] !== mconf[k] || cnt_o[k] !== 8'(mcnt[k]) ||
                (rise_o[k] & fall_o[k]) !== 8'h00) begin
               errors++;
               $display("FAIL random inst%0d cyc%0d q=%h/%h rise=%h/%h fall=%h/%h conf=%h/%h cnt=%0d/%0d",
                        k, c, q_o[k], mq[k], rise_o[k], mrise[k], fall_o[k], mfall[k],
                        conf_o[k], mconf[k], cnt_o[k], mcnt[k]);
            end
         end
      end
   endtask

   initial begin
      for (int k = 0; k < NI; k++) begin
         mmode[k] = (k < 4) ? k : 0;
         mmax[k]  = (k < 4) ? 255 : 3;
         mq[k] = RV; mrise[k] = 0; mfall[k] = 0; mconf[k] = 0; mcnt[k] = 0;
      end
      rst = 1'b1; en = 1'b0; s = 8'h00; r = 8'h00; clr_err = 1'b0;
      test_reset();
      test_set_reset();
      test_enable_hold();
      test_conflict_modes();
      test_saturation();
      test_clr_with_conflict();
      test_reset_mid_toggle();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
